parking_gate_controller: RTL

Sequences the 4-slot parking allocator against the physical entry and exit barriers. It arbitrates between entry and exit sensor requests and issues one-cycle allocate/free pulses to the slot manager. It captures the slot manager's registered result and holds the matching barrier open for a minimum time and until the vehicle clears. It sits between the sensor/barrier I/O and the slot manager in the lot top level.

---
 rtl/parking_pkg.sv | 34 +++
 rtl/parking_gate_controller_timer.sv | 39 +++
 rtl/parking_gate_controller.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller and its timer.
package parking_pkg;

   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;
   localparam int COUNT_W   = 3;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_ALLOC       = 3'd1,
      ST_ALLOC_WAIT  = 3'd2,
      ST_ENTRY_OPEN  = 3'd3,
      ST_FREE        = 3'd4,
      ST_FREE_WAIT   = 3'd5,
      ST_EXIT_OPEN   = 3'd6,
      ST_REJECT_WAIT = 3'd7
   } pgc_state_e;

   typedef enum logic {
      SIDE_EXIT  = 1'b0,
      SIDE_ENTRY = 1'b1
   } pgc_side_e;

   // True when the slot manager still has at least one free slot.
   function automatic logic has_free(input logic [COUNT_W-1:0] fc);
      return (fc != 3'd0);
   endfunction

   // True when at least one slot is occupied, i.e. a free request makes sense.
   function automatic logic has_occupied(input logic [COUNT_W-1:0] fc);
      return (fc < COUNT_W'(NUM_SLOTS));
   endfunction

endpackage

// File: rtl/parking_gate_controller_timer.sv
// gate_hold_timer: loadable down-counter that saturates at zero and flags it.
module gate_hold_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Load wins over decrement; decrement stops at zero instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != {W{1'b0}})) begin
         count_d = count_q - {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == {W{1'b0}});

endmodule

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: arbitrates entry/exit sensors, pulses the slot
// manager and holds the matching barrier open for a minimum time and until
// the vehicle clears. Optional macro PGC_TIMEOUT_EN adds a stuck-vehicle
// timeout that raises a sticky fault and closes the gate.
module parking_gate_controller
   import parking_pkg::*;
#(
   parameter int GATE_CYCLES    = 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               entry_sensor,
   input  logic               exit_sensor,
   input  logic [SLOT_W-1:0]  exit_sel_in,
   input  logic [COUNT_W-1:0] free_count,
   input  logic [SLOT_W-1:0]  allocated_slot,
   input  logic [SLOT_W-1:0]  exit_slot,
   output logic               alloc_req,
   output logic               free_req,
   output logic [SLOT_W-1:0]  exit_car_select,
   output logic               entry_gate_open,
   output logic               exit_gate_open,
   output logic [SLOT_W-1:0]  assigned_slot,
   output logic               lot_full,
   output logic               reject,
   output logic               busy,
   output logic               fault
);

   localparam int               CNT_W     = $clog2(GATE_CYCLES + 1);
   localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES);

   pgc_state_e        state_q, state_d;
   pgc_side_e         last_served_q, last_served_d;
   pgc_side_e         rej_side_q, rej_side_d;
   logic [SLOT_W-1:0] assigned_slot_q, assigned_slot_d;
   logic [SLOT_W-1:0] exit_car_select_q, exit_car_select_d;
   logic              alloc_req_q, alloc_req_d;
   logic              free_req_q, free_req_d;
   logic              entry_gate_open_q, entry_gate_open_d;
   logic              exit_gate_open_q, exit_gate_open_d;
   logic              lot_full_q, lot_full_d;
   logic              reject_q, reject_d;
   logic              busy_q, busy_d;
   logic              fault_q, fault_d;

   logic              pick_entry_s;
   logic              gate_load_s;
   logic              gate_dec_s;
   logic              gate_zero_s;
   logic              tmo_zero_s;

   // The freed-slot echo is informational only; the slot manager owns it.
   logic              unused_exit_slot_s;
   assign unused_exit_slot_s = ^exit_slot;

   gate_hold_timer #(
      .W (CNT_W)
   ) u_gate_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (gate_load_s),
      .load_val (GATE_LOAD),
      .dec      (gate_dec_s),
      .zero     (gate_zero_s)
   );

`ifdef PGC_TIMEOUT_EN
   localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

   // Shares load/decrement strobes with the gate timer so both start together.
   gate_hold_timer #(
      .W (TMO_W)
   ) u_tmo_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (gate_load_s),
      .load_val (TMO_LOAD),
      .dec      (gate_dec_s),
      .zero     (tmo_zero_s)
   );
`else
   logic [31:0] unused_tmo_cfg_s;
   assign unused_tmo_cfg_s = TIMEOUT_CYCLES;
   assign tmo_zero_s       = 1'b0;
`endif

   // Next-state logic: arbitration in IDLE, pulse/wait/open sequencing after.
   always_comb begin
      state_d           = state_q;
      last_served_d     = last_served_q;
      rej_side_d        = rej_side_q;
      assigned_slot_d   = assigned_slot_q;
      exit_car_select_d = exit_car_select_q;
      fault_d           = fault_q;
      reject_d          = 1'b0;
      gate_load_s       = 1'b0;
      gate_dec_s        = 1'b0;
      pick_entry_s      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (entry_sensor && exit_sensor) begin
               // A full lot lets the exit go first; otherwise alternate.
               if (!has_free(free_count)) begin
                  pick_entry_s = 1'b0;
               end else begin
                  pick_entry_s = (last_served_q == SIDE_EXIT);
               end
            end else begin
               pick_entry_s = entry_sensor;
            end

            if (pick_entry_s) begin
               if (has_free(free_count)) begin
                  state_d       = ST_ALLOC;
                  last_served_d = SIDE_ENTRY;
               end else begin
                  state_d    = ST_REJECT_WAIT;
                  rej_side_d = SIDE_ENTRY;
                  reject_d   = 1'b1;
               end
            end else if (exit_sensor) begin
               if (has_occupied(free_count)) begin
                  state_d           = ST_FREE;
                  last_served_d     = SIDE_EXIT;
                  exit_car_select_d = exit_sel_in;
               end else begin
                  state_d    = ST_REJECT_WAIT;
                  rej_side_d = SIDE_EXIT;
                  reject_d   = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ALLOC: begin
            state_d = ST_ALLOC_WAIT;
         end

         ST_ALLOC_WAIT: begin
            // Slot manager result is registered, so it is valid one cycle after the pulse.
            assigned_slot_d = allocated_slot;
            gate_load_s     = 1'b1;
            state_d         = ST_ENTRY_OPEN;
         end

         ST_ENTRY_OPEN: begin
            gate_dec_s = 1'b1;
            if (gate_zero_s && !entry_sensor) begin
               state_d = ST_IDLE;
            end else if (tmo_zero_s && entry_sensor) begin
               fault_d    = 1'b1;
               rej_side_d = SIDE_ENTRY;
               state_d    = ST_REJECT_WAIT;
            end else begin
               state_d = ST_ENTRY_OPEN;
            end
         end

         ST_FREE: begin
            state_d = ST_FREE_WAIT;
         end

         ST_FREE_WAIT: begin
            gate_load_s = 1'b1;
            state_d     = ST_EXIT_OPEN;
         end

         ST_EXIT_OPEN: begin
            gate_dec_s = 1'b1;
            if (gate_zero_s && !exit_sensor) begin
               state_d = ST_IDLE;
            end else if (tmo_zero_s && exit_sensor) begin
               fault_d    = 1'b1;
               rej_side_d = SIDE_EXIT;
               state_d    = ST_REJECT_WAIT;
            end else begin
               state_d = ST_EXIT_OPEN;
            end
         end

         ST_REJECT_WAIT: begin
            // Wait for the refused vehicle to leave so it is rejected only once.
            if (rej_side_q == SIDE_ENTRY) begin
               if (!entry_sensor) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_REJECT_WAIT;
               end
            end else begin
               if (!exit_sensor) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_REJECT_WAIT;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output comes straight from a flop.
   always_comb begin
      alloc_req_d       = (state_d == ST_ALLOC);
      free_req_d        = (state_d == ST_FREE);
      entry_gate_open_d = (state_d == ST_ENTRY_OPEN);
      exit_gate_open_d  = (state_d == ST_EXIT_OPEN);
      busy_d            = (state_d != ST_IDLE);
      lot_full_d        = !has_free(free_count);
   end

   // State and output registers; reset closes both gates immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= ST_IDLE;
         last_served_q     <= SIDE_EXIT;
         rej_side_q        <= SIDE_EXIT;
         assigned_slot_q   <= {SLOT_W{1'b0}};
         exit_car_select_q <= {SLOT_W{1'b0}};
         alloc_req_q       <= 1'b0;
         free_req_q        <= 1'b0;
         entry_gate_open_q <= 1'b0;
         exit_gate_open_q  <= 1'b0;
         lot_full_q        <= 1'b0;
         reject_q          <= 1'b0;
         busy_q            <= 1'b0;
         fault_q           <= 1'b0;
      end else begin
         state_q           <= state_d;
         last_served_q     <= last_served_d;
         rej_side_q        <= rej_side_d;
         assigned_slot_q   <= assigned_slot_d;
         exit_car_select_q <= exit_car_select_d;
         alloc_req_q       <= alloc_req_d;
         free_req_q        <= free_req_d;
         entry_gate_open_q <= entry_gate_open_d;
         exit_gate_open_q  <= exit_gate_open_d;
         lot_full_q        <= lot_full_d;
         reject_q          <= reject_d;
         busy_q            <= busy_d;
         fault_q           <= fault_d;
      end
   end

   assign alloc_req       = alloc_req_q;
   assign free_req        = free_req_q;
   assign exit_car_select = exit_car_select_q;
   assign entry_gate_open = entry_gate_open_q;
   assign exit_gate_open  = exit_gate_open_q;
   assign assigned_slot   = assigned_slot_q;
   assign lot_full        = lot_full_q;
   assign reject          = reject_q;
   assign busy            = busy_q;
   assign fault           = fault_q;

endmodule
